// File: rtl/gpu_wb_arbiter.sv
// Two-port round-robin Wishbone master arbiter for the GPU slave port.
// One outstanding transaction, registered bus outputs, ack-timeout watchdog.
module gpu_wb_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                r0_req,
   input  logic                r0_we,
   input  logic [DATA_W/8-1:0] r0_sel,
   input  logic [ADDR_W-1:0]   r0_adr,
   input  logic [DATA_W-1:0]   r0_dat,
   output logic [DATA_W-1:0]   r0_rdata,
   output logic                r0_done,
   output logic                r0_err,
   input  logic                r1_req,
   input  logic                r1_we,
   input  logic [DATA_W/8-1:0] r1_sel,
   input  logic [ADDR_W-1:0]   r1_adr,
   input  logic [DATA_W-1:0]   r1_dat,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic                r1_done,
   output logic                r1_err,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);

   state_t              state_r;
   logic                last_grant_r;
   logic                grant_r;
   logic [15:0]         cnt_r;

   logic                req_any_s;
   logic                grant_s;
   logic                we_s;
   logic [DATA_W/8-1:0] sel_s;
   logic [ADDR_W-1:0]   adr_s;
   logic [DATA_W-1:0]   dat_s;

   // Round-robin pick and payload mux for the port that would win this cycle
   always_comb begin
      req_any_s = r0_req | r1_req;
      grant_s   = 1'b0;
      if (r0_req && r1_req) begin
         grant_s = ~last_grant_r;
      end else if (r1_req) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
      if (grant_s) begin
         we_s  = r1_we;
         sel_s = r1_sel;
         adr_s = r1_adr;
         dat_s = r1_dat;
      end else begin
         we_s  = r0_we;
         sel_s = r0_sel;
         adr_s = r0_adr;
         dat_s = r0_dat;
      end
   end

   // Arbiter FSM with registered bus outputs, response pulses and watchdog
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         grant_r      <= 1'b0;
         cnt_r        <= 16'd0;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_sel_o     <= '0;
         wb_adr_o     <= '0;
         wb_dat_o     <= '0;
         r0_rdata     <= '0;
         r1_rdata     <= '0;
         r0_done      <= 1'b0;
         r0_err       <= 1'b0;
         r1_done      <= 1'b0;
         r1_err       <= 1'b0;
      end else begin
         r0_done <= 1'b0;
         r0_err  <= 1'b0;
         r1_done <= 1'b0;
         r1_err  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_any_s) begin
                  grant_r      <= grant_s;
                  last_grant_r <= grant_s;
                  wb_we_o      <= we_s;
                  wb_sel_o     <= sel_s;
                  wb_adr_o     <= adr_s;
                  wb_dat_o     <= dat_s;
                  wb_cyc_o     <= 1'b1;
                  wb_stb_o     <= 1'b1;
                  cnt_r        <= 16'd0;
                  state_r      <= BUS;
               end else begin
                  state_r <= IDLE;
               end
            end
            BUS: begin
               // Ack is checked first so a terminal-count ack still completes
               if (wb_ack_i) begin
                  if (grant_r) begin
                     r1_rdata <= wb_dat_i;
                     r1_done  <= 1'b1;
                  end else begin
                     r0_rdata <= wb_dat_i;
                     r0_done  <= 1'b1;
                  end
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  state_r  <= RESP;
               end else if (cnt_r == TERM_CNT) begin
                  if (grant_r) begin
                     r1_err <= 1'b1;
                  end else begin
                     r0_err <= 1'b1;
                  end
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  state_r  <= RESP;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_wb_arbiter.sv
// Directed bench for gpu_wb_arbiter: scoreboarded bus cycles and responses
// against a simple slave model with programmable ack latency.
module tb_gpu_wb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          r0_req = 1'b0, r1_req = 1'b0;
   logic          r0_we = 1'b0, r1_we = 1'b0;
   logic [3:0]    r0_sel = 4'h0, r1_sel = 4'h0;
   logic [AW-1:0] r0_adr = '0, r1_adr = '0;
   logic [DW-1:0] r0_dat = '0, r1_dat = '0;
   logic [DW-1:0] r0_rdata, r1_rdata;
   logic          r0_done, r0_err, r1_done, r1_err;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]    wb_sel_o;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i = 1'b0;

   always #5 clk = ~clk;

   gpu_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_sel(r0_sel), .r0_adr(r0_adr), .r0_dat(r0_dat),
      .r0_rdata(r0_rdata), .r0_done(r0_done), .r0_err(r0_err),
      .r1_req(r1_req), .r1_we(r1_we), .r1_sel(r1_sel), .r1_adr(r1_adr), .r1_dat(r1_dat),
      .r1_rdata(r1_rdata), .r1_done(r1_done), .r1_err(r1_err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   typedef struct {
      logic          port;
      logic          we;
      logic [3:0]    sel;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      int            len;
      logic          err;
      logic [DW-1:0] rdata;
   } txn_t;

   txn_t          bus_q[$];
   txn_t          resp_q[$];
   logic [DW-1:0] exp_rd[2];
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave model: ack in the ack_at-th cycle of a bus cycle (0 = never)
   int            ack_at = 0;
   int            bus_cyc = 0;
   logic          stray_ack = 1'b0;
   logic [DW-1:0] slave_base = 32'h0;
   assign wb_dat_i = slave_base ^ wb_adr_o;

   always @(negedge clk) begin
      if (wb_cyc_o) begin
         bus_cyc  = bus_cyc + 1;
         wb_ack_i = (ack_at != 0) && (bus_cyc == ack_at);
      end else begin
         bus_cyc  = 0;
         wb_ack_i = stray_ack;
      end
   end

   // Monitor: bus payload/stability/length and response pulses vs scoreboard
   logic prev_cyc = 1'b0;
   logic have_cur = 1'b0;
   int   cyc_len = 0;
   txn_t cur;
   txn_t rt;

   always @(negedge clk) begin
      if (wb_cyc_o) begin
         if (!prev_cyc) begin
            cyc_len = 0;
            if (bus_q.size() == 0) begin
               check("bus_unexpected", 64'd1, 64'd0);
            end else begin
               cur      = bus_q.pop_front();
               have_cur = 1'b1;
            end
         end
         cyc_len++;
         if (have_cur) begin
            check("bus_stb", {63'd0, wb_stb_o}, 64'd1);
            check("bus_we", {63'd0, wb_we_o}, {63'd0, cur.we});
            check("bus_sel", {60'd0, wb_sel_o}, {60'd0, cur.sel});
            check("bus_adr", {32'd0, wb_adr_o}, {32'd0, cur.adr});
            check("bus_dat", {32'd0, wb_dat_o}, {32'd0, cur.dat});
         end
      end else begin
         check("stb_idle", {63'd0, wb_stb_o}, 64'd0);
         if (prev_cyc && have_cur && !reset) begin
            check("bus_len", 64'(cyc_len), 64'(cur.len));
         end
         have_cur = 1'b0;
      end
      prev_cyc = wb_cyc_o;
      if (r0_done || r0_err || r1_done || r1_err) begin
         if (resp_q.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
         end else begin
            rt = resp_q.pop_front();
            check("r0_done", {63'd0, r0_done}, {63'd0, !rt.port && !rt.err});
            check("r0_err", {63'd0, r0_err}, {63'd0, !rt.port && rt.err});
            check("r1_done", {63'd0, r1_done}, {63'd0, rt.port && !rt.err});
            check("r1_err", {63'd0, r1_err}, {63'd0, rt.port && rt.err});
            check("rdata", {32'd0, rt.port ? r1_rdata : r0_rdata}, {32'd0, rt.rdata});
         end
      end
   end

   // Builds the expected transaction and pushes it to both scoreboards
   task automatic expect_txn(input logic port, input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat, input int ack);
      txn_t t;
      t.port = port; t.we = we; t.sel = sel; t.adr = adr; t.dat = dat;
      t.err  = (ack == 0) || (ack > TO);
      t.len  = t.err ? TO : ack;
      if (!t.err) exp_rd[port] = slave_base ^ adr;
      t.rdata = exp_rd[port];
      bus_q.push_back(t);
      resp_q.push_back(t);
   endtask

   // One transaction on one port; mode 1 drops req during BUS, mode 2 mutates payload
   task automatic run1(input logic port, input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] dat, input int ack, input int mode);
      logic seen;
      seen = 1'b0;
      ack_at = ack;
      if (port) begin r1_we = we; r1_sel = sel; r1_adr = adr; r1_dat = dat; end
      else begin r0_we = we; r0_sel = sel; r0_adr = adr; r0_dat = dat; end
      expect_txn(port, we, sel, adr, dat, ack);
      @(negedge clk);
      if (port) r1_req = 1'b1; else r0_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wb_cyc_o && mode == 1) begin r0_req = 1'b0; r1_req = 1'b0; end
         if (wb_cyc_o && mode == 2) begin r0_adr = 32'hFFFF_FFFF; r0_dat = 32'h0; r0_we = ~we; end
         if (port ? (r1_done || r1_err) : (r0_done || r0_err)) begin
            seen = 1'b1;
            break;
         end
      end
      check("run_response_seen", {63'd0, seen}, 64'd1);
      r0_req = 1'b0;
      r1_req = 1'b0;
      @(negedge clk);
   endtask

   // Both ports held high for n transactions; checks 3-cycle done spacing
   task automatic contend(input int n);
      int dones;
      int last_cyc;
      dones = 0;
      last_cyc = 0;
      ack_at = 1;
      @(negedge clk);
      r0_req = 1'b1;
      r1_req = 1'b1;
      for (int i = 1; i < 100; i++) begin
         @(negedge clk);
         if (r0_done || r1_done) begin
            if (dones > 0) check("done_spacing", 64'(i - last_cyc), 64'd3);
            last_cyc = i;
            dones++;
            if (dones == n) break;
         end
      end
      check("contend_count", 64'(dones), 64'(n));
      r0_req = 1'b0;
      r1_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      slave_base = 32'h0BAD_F00D;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
      check("rst_bus", {wb_adr_o, wb_dat_o}, 64'd0);
      check("rst_misc", {58'd0, wb_we_o, wb_sel_o, wb_stb_o}, 64'd0);
      check("rst_rdata", {r0_rdata, r1_rdata}, 64'd0);
      check("rst_pulses", {60'd0, r0_done, r0_err, r1_done, r1_err}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single write, ack in 2nd BUS cycle
      run1(1'b0, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 2, 0);

      // Read on port 1 returning 0x12345678
      slave_base = 32'h1234_5678 ^ 32'h0000_0040;
      run1(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 1, 0);
      check("r1_rdata_held", {32'd0, r1_rdata}, 64'h1234_5678);
      check("r0_rdata_kept", {32'd0, r0_rdata}, {32'd0, exp_rd[0]});

      // Contention: grants alternate 0,1,0,1
      slave_base = 32'h5555_0000;
      r0_we = 1'b1; r0_sel = 4'h3; r0_adr = 32'h0000_0100; r0_dat = 32'hAAAA_0000;
      r1_we = 1'b0; r1_sel = 4'hC; r1_adr = 32'h0000_0200; r1_dat = 32'hBBBB_0000;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) expect_txn(1'b0, 1'b1, 4'h3, 32'h0000_0100, 32'hAAAA_0000, 1);
         else            expect_txn(1'b1, 1'b0, 4'hC, 32'h0000_0200, 32'hBBBB_0000, 1);
      end
      contend(4);

      // Timeout, then a normal transaction
      slave_base = 32'h0F0F_0F0F;
      run1(1'b0, 1'b0, 4'h1, 32'h0000_0300, 32'h1111_1111, 0, 0);
      check("timeout_rdata_kept", {32'd0, r0_rdata}, {32'd0, exp_rd[0]});
      run1(1'b0, 1'b1, 4'h2, 32'h0000_0304, 32'h2222_2222, 3, 0);

      // Ack coinciding with terminal count
      run1(1'b0, 1'b0, 4'hF, 32'h0000_0308, 32'h0, TO, 0);

      // Ack outside BUS is ignored
      stray_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stray_ack_cyc", {63'd0, wb_cyc_o}, 64'd0);
      end
      stray_ack = 1'b0;
      @(negedge clk);

      // Req dropped during BUS still completes; payload changes after grant are ignored
      run1(1'b1, 1'b1, 4'h6, 32'h0000_0400, 32'h3333_3333, 3, 1);
      run1(1'b0, 1'b1, 4'h9, 32'h0000_0500, 32'h4444_4444, 4, 2);

      // Reset in the middle of a bus cycle
      ack_at = 0;
      r0_we = 1'b1; r0_sel = 4'hF; r0_adr = 32'h0000_0600; r0_dat = 32'h5555_5555;
      expect_txn(1'b0, 1'b1, 4'hF, 32'h0000_0600, 32'h5555_5555, 0);
      @(negedge clk);
      r0_req = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_reset_cyc", {63'd0, wb_cyc_o}, 64'd1);
      reset = 1'b1;
      r0_req = 1'b0;
      @(negedge clk);
      check("mid_reset_cycstb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
      check("mid_reset_pulses", {60'd0, r0_done, r0_err, r1_done, r1_err}, 64'd0);
      check("mid_reset_rdata", {r0_rdata, r1_rdata}, 64'd0);
      resp_q.delete();
      exp_rd[0] = 32'h0;
      exp_rd[1] = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      r0_we = 1'b0; r0_sel = 4'hF; r0_adr = 32'h0000_0700; r0_dat = 32'h0;
      r1_we = 1'b1; r1_sel = 4'hF; r1_adr = 32'h0000_0800; r1_dat = 32'h6666_6666;
      expect_txn(1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'h0, 1);
      expect_txn(1'b1, 1'b1, 4'hF, 32'h0000_0800, 32'h6666_6666, 1);
      contend(2);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(bus_q.size() + resp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
